// File: rtl/alu_pkg.sv
// Shared opcode and controller-state types for the ALU with its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_XOR   = 4'h3,
    OP_ANDN  = 4'h4,
    OP_ORN   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLTU  = 4'h8,
    OP_SLL   = 4'h9,
    OP_SRL   = 4'hA,
    OP_SRA   = 4'hB,
    OP_MULTU = 4'hC,
    OP_DIVU  = 4'hD,
    OP_MFHI  = 4'hE,
    OP_MFLO  = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  function automatic logic is_iterative(input alu_op_t op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// hi_o/lo_o present the final step's values in the cycle done_o is high so the caller can register them.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic             isDiv_q, isDiv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH-1:0] mulAddend;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] stepAcc, stepLo;

  // acc holds the running high product (mul) or partial remainder (div); lo holds multiplier or quotient
  assign mulAddend = lo_q[0] ? opnd_q : {WIDTH{1'b0}};
  assign mulSum    = {1'b0, acc_q} + {1'b0, mulAddend};
  assign divShift  = {acc_q, lo_q[WIDTH-1]};
  assign divFits   = divShift >= {1'b0, opnd_q};

  always_comb begin
    stepAcc = acc_q;
    stepLo  = lo_q;
    if (isDiv_q) begin
      stepAcc = divFits ? (divShift[WIDTH-1:0] - opnd_q) : divShift[WIDTH-1:0];
      stepLo  = {lo_q[WIDTH-2:0], divFits};
    end else begin
      {stepAcc, stepLo} = {mulSum, lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = stepAcc;
  assign lo_o   = stepLo;

  always_comb begin
    busy_d  = busy_q;
    isDiv_d = isDiv_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    if (start_i) begin
      busy_d  = 1'b1;
      isDiv_d = op_i;
      cnt_d   = '0;
      acc_d   = '0;
      lo_d    = a_i;
      opnd_d  = b_i;
    end else if (busy_q) begin
      acc_d = stepAcc;
      lo_d  = stepLo;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      isDiv_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      isDiv_q <= isDiv_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered-output ALU with valid/ready handshakes and architectural HI/LO fed by an iterative MDU.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  mdu_state_t       state_q, state_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  alu_op_t          op;
  logic             accept;
  logic             startIter;
  logic             iterDone;
  logic [WIDTH-1:0] iterHi, iterLo;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   addSum, subSum;
  logic [WIDTH-1:0] aluY;
  logic             aluCout, aluOvf;

  assign op     = alu_op_t'(f);
  assign shamt  = b[SHW-1:0];
  assign addSum = {1'b0, a} + {1'b0, b};
  assign subSum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  always_comb begin
    aluY    = '0;
    aluCout = 1'b0;
    aluOvf  = 1'b0;
    case (op)
      OP_AND:  aluY = a & b;
      OP_OR:   aluY = a | b;
      OP_ADD: begin
        aluY    = addSum[WIDTH-1:0];
        aluCout = addSum[WIDTH];
        aluOvf  = (a[WIDTH-1] == b[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  aluY = a ^ b;
      OP_ANDN: aluY = a & ~b;
      OP_ORN:  aluY = a | ~b;
      OP_SUB: begin
        aluY    = subSum[WIDTH-1:0];
        aluCout = subSum[WIDTH];
        aluOvf  = (a[WIDTH-1] != b[WIDTH-1]) && (subSum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  aluY = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: aluY = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  aluY = a << shamt;
      OP_SRL:  aluY = a >> shamt;
      OP_SRA:  aluY = $signed(a) >>> shamt;
      OP_MFHI: aluY = hi_q;
      OP_MFLO: aluY = lo_q;
      default: aluY = '0;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign startIter = accept && is_iterative(op);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (startIter),
    .op_i    (op == OP_DIVU),
    .a_i     (a),
    .b_i     (b),
    .done_o  (iterDone),
    .hi_o    (iterHi),
    .lo_o    (iterLo)
  );

  // An accepted MULTU/DIVU retires any held result; HI/LO only change on completion
  always_comb begin
    state_d    = state_q;
    outValid_d = outValid_q;
    y_d        = y_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (accept) begin
      if (op == OP_MULTU) begin
        state_d    = MUL;
        outValid_d = 1'b0;
      end else if (op == OP_DIVU) begin
        state_d    = DIV;
        outValid_d = 1'b0;
      end else begin
        y_d        = aluY;
        cout_d     = aluCout;
        ovf_d      = aluOvf;
        outValid_d = 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (iterDone) begin
        state_d    = IDLE;
        hi_d       = iterHi;
        lo_d       = iterLo;
        y_d        = iterLo;
        cout_d     = 1'b0;
        ovf_d      = 1'b0;
        outValid_d = 1'b1;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      y_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      y_q        <= y_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign out_valid = outValid_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = (y_q == '0);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed literal cases plus randomized traffic checked every cycle
// against a transaction-level model built from plain arithmetic.
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   f;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one operation, computed with 64-bit integer arithmetic
  function automatic void refOp(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] z,
                                input logic [W-1:0] curHi, input logic [W-1:0] curLo,
                                output logic [W-1:0] ry, output logic rc, output logic rv,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    longint          sx, sz, sr;
    longint unsigned ux, uz, ur;
    int              sh;
    sx  = longint'($signed(x));
    sz  = longint'($signed(z));
    ux  = {32'b0, x};
    uz  = {32'b0, z};
    sh  = int'(z[4:0]);
    ry  = '0;
    rc  = 1'b0;
    rv  = 1'b0;
    rhi = curHi;
    rlo = curLo;
    case (op)
      4'h0: ry = x & z;
      4'h1: ry = x | z;
      4'h2: begin
        ur = ux + uz;
        ry = ur[31:0];
        rc = ur[32];
        sr = sx + sz;
        rv = (sr != longint'($signed(sr[31:0])));
      end
      4'h3: ry = x ^ z;
      4'h4: ry = x & ~z;
      4'h5: ry = x | ~z;
      4'h6: begin
        ry = x - z;
        rc = (x >= z);
        sr = sx - sz;
        rv = (sr != longint'($signed(sr[31:0])));
      end
      4'h7: ry = (sx < sz) ? 32'd1 : 32'd0;
      4'h8: ry = (ux < uz) ? 32'd1 : 32'd0;
      4'h9: begin ur = ux << sh; ry = ur[31:0]; end
      4'hA: ry = x >> sh;
      4'hB: begin sr = sx >>> sh; ry = sr[31:0]; end
      4'hC: begin
        ur  = ux * uz;
        rhi = ur[63:32];
        rlo = ur[31:0];
        ry  = rlo;
      end
      4'hD: begin
        if (z == '0) begin
          rlo = '1;
          rhi = x;
        end else begin
          rlo = x / z;
          rhi = x % z;
        end
        ry = rlo;
      end
      4'hE: ry = curHi;
      default: ry = curLo;
    endcase
  endfunction

  logic         mValid;
  logic [W-1:0] mY, mHi, mLo, pHi, pLo;
  logic         mC, mV;
  int           mBusy;
  logic [W-1:0] ry, rhi, rlo;
  logic         rc, rv;

  // Transaction model: a pending MULTU/DIVU counts down W edges before its result appears
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mValid = 1'b0; mY = '0; mC = 1'b0; mV = 1'b0;
      mHi = '0; mLo = '0; pHi = '0; pLo = '0; mBusy = 0;
    end else if (mBusy > 0) begin
      mBusy--;
      if (mBusy == 0) begin
        mHi = pHi; mLo = pLo; mY = pLo; mC = 1'b0; mV = 1'b0; mValid = 1'b1;
      end
    end else if (in_valid && (!mValid || out_ready)) begin
      refOp(f, a, b, mHi, mLo, ry, rc, rv, rhi, rlo);
      if (f == 4'hC || f == 4'hD) begin
        pHi = rhi; pLo = rlo; mBusy = W; mValid = 1'b0;
      end else begin
        mY = ry; mC = rc; mV = rv; mValid = 1'b1;
      end
    end else if (mValid && out_ready) begin
      mValid = 1'b0;
    end
  end

  always @(negedge clk) begin
    checkOutput("out_valid", out_valid, mValid);
    checkOutput("in_ready", in_ready, (mBusy == 0) && (!mValid || out_ready));
    checkOutput("hi", hi, mHi);
    checkOutput("lo", lo, mLo);
    if (mValid) begin
      checkOutput("y", y, mY);
      checkOutput("cout", cout, mC);
      checkOutput("ovf", ovf, mV);
      checkOutput("zero", zero, mY == '0);
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                               output int lat, output int lowCnt);
    int n;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("ready_timeout", in_ready, 1);
    f = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 1;
    lowCnt = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) lowCnt++;
      @(posedge clk); #2;
      lat++;
    end
    checkOutput("valid_timeout", out_valid, 1);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0]   bbOp  [4];
  logic [W-1:0] bbA   [4];
  logic [W-1:0] bbB   [4];
  logic [W-1:0] bbExp [4];

  initial begin
    int lat, lowCnt;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; f = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_y", y, 0);
    checkOutput("rst_zero", zero, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_hilo", {hi, lo}, 0);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_ready", in_ready, 1);

    applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h1, lat, lowCnt);
    checkOutput("add_lat", lat, 1);
    checkOutput("add_y", y, 0);
    checkOutput("add_cout", cout, 1);
    checkOutput("add_zero", zero, 1);
    checkOutput("add_ovf", ovf, 0);
    applyStimulus(4'h2, 32'h7FFF_FFFF, 32'h1, lat, lowCnt);
    checkOutput("addovf_y", y, 32'h8000_0000);
    checkOutput("addovf_ovf", ovf, 1);
    checkOutput("addovf_cout", cout, 0);

    applyStimulus(4'h7, 32'hFFFF_FFFF, 32'h1, lat, lowCnt);
    checkOutput("slt_y", y, 1);
    applyStimulus(4'h8, 32'hFFFF_FFFF, 32'h1, lat, lowCnt);
    checkOutput("sltu_y", y, 0);
    applyStimulus(4'hB, 32'h8000_0000, 32'h4, lat, lowCnt);
    checkOutput("sra_y", y, 32'hF800_0000);

    applyStimulus(4'hC, 32'hFFFF_FFFF, 32'h2, lat, lowCnt);
    checkOutput("mul_lat", lat, 33);
    checkOutput("mul_ready_low", lowCnt, 32);
    checkOutput("mul_hi", hi, 1);
    checkOutput("mul_lo", lo, 32'hFFFF_FFFE);
    checkOutput("mul_y", y, 32'hFFFF_FFFE);
    applyStimulus(4'hE, 32'h0, 32'h0, lat, lowCnt);
    checkOutput("mfhi_y", y, 1);

    applyStimulus(4'hD, 32'd100, 32'd7, lat, lowCnt);
    checkOutput("div_lo", lo, 14);
    checkOutput("div_hi", hi, 2);
    applyStimulus(4'hD, 32'd5, 32'd0, lat, lowCnt);
    checkOutput("div0_lat", lat, 33);
    checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
    checkOutput("div0_hi", hi, 5);

    applyStimulus(4'h2, 32'd20, 32'd22, lat, lowCnt);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checkOutput("hold_y", y, 42);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_ready", in_ready, 0);
    end

    bbOp[0] = 4'h0; bbA[0] = 32'h0000_00F0; bbB[0] = 32'h0000_0F0F; bbExp[0] = 32'h0000_0000;
    bbOp[1] = 4'h1; bbA[1] = 32'h0000_00F0; bbB[1] = 32'h0000_0F0F; bbExp[1] = 32'h0000_0FFF;
    bbOp[2] = 4'h3; bbA[2] = 32'h0000_00FF; bbB[2] = 32'h0000_0F0F; bbExp[2] = 32'h0000_0FF0;
    bbOp[3] = 4'h6; bbA[3] = 32'd5;         bbB[3] = 32'd7;         bbExp[3] = 32'hFFFF_FFFE;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = bbOp[i]; a = bbA[i]; b = bbB[i];
      @(posedge clk); #2;
      checkOutput("b2b_valid", out_valid, 1);
      checkOutput("b2b_y", y, bbExp[i]);
    end
    in_valid = 1'b0;
    checkOutput("b2b_sub_cout", cout, 0);

    #1;
    while (!in_ready) begin
      @(posedge clk); #2;
    end
    f = 4'hC; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    checkOutput("abort_zero", zero, 1);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    checkOutput("abort_ready", in_ready, 1);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      f         = 4'($urandom_range(0, 15));
      a         = pickOperand();
      b         = pickOperand();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits, with legal values 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept an operation.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the operands.
REQ-007 The block SHALL have port f, input, 4, the opcode (see REQ-012).
REQ-008 The block SHALL have port out_valid, output, 1, meaning y and the flags hold a result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have ports y (output, WIDTH, result), cout (output, 1, carry), ovf (output, 1, signed overflow) and zero (output, 1, y==0).
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, the architectural HI/LO registers.

Function
REQ-012 Opcodes SHALL be:
- 0 AND; 1 OR; 2 ADD; 3 XOR; 4 a&~b; 5 a|~b; 6 SUB
- 7 SLT (signed); 8 SLTU; 9 SLL; A SRL; B SRA
- C MULTU; D DIVU; E MFHI (y=hi); F MFLO (y=lo)
REQ-013 An operation SHALL be accepted when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 Shift amount SHALL be b[$clog2(WIDTH)-1:0]; a is the value shifted.
REQ-015 Single-cycle ops (0-B, E, F) SHALL register their result; accept at edge N gives out_valid=1 after edge N+1.
REQ-016 ADD: cout = bit WIDTH of a+b; SUB: cout = carry of a+~b+1; ovf = two's-complement overflow for ADD/SUB; cout=ovf=0 for all other ops.
REQ-017 SLT/SLTU SHALL give y=1 or 0, zero-extended.
REQ-018 State machine SHALL have states IDLE, MUL and DIV; MULTU/DIVU accepted in IDLE enter MUL/DIV, run exactly WIDTH iterations, and return to IDLE with out_valid=1 after edge N+WIDTH+1.
REQ-019 MULTU SHALL use unsigned shift-add: {hi,lo} = a*b.
REQ-020 DIVU SHALL use unsigned restoring division: lo = quotient, hi = remainder.
REQ-021 Divide-by-zero SHALL take the same WIDTH cycles and give lo = all-ones, hi = a.
REQ-022 For MULTU/DIVU, y SHALL equal the new lo; hi/lo SHALL update only at completion.
REQ-023 in_ready SHALL be 0 throughout MUL/DIV.
REQ-024 Output SHALL hold y, flags and out_valid stable while out_valid && !out_ready.
REQ-025 When out_valid && out_ready && in_valid with in_ready, the new operation SHALL be accepted in the same cycle (full throughput for single-cycle ops).
REQ-026 out_valid SHALL fall after a handshake with no new accept.
REQ-027 zero SHALL be derived from registered y.

Reset
REQ-028 reset_n low SHALL immediately force state=IDLE, out_valid=0, y=0, cout=0, ovf=0, hi=0, lo=0 and the iteration counter to 0.
REQ-029 During reset, zero SHALL read 1 and in_ready SHALL read 1 (once reset_n is high).
REQ-030 Reset during MUL/DIV SHALL abort the operation with no partial hi/lo update.

Structure
REQ-031 Package alu_pkg SHALL hold enum alu_op_t (4-bit opcodes) and enum mdu_state_t (IDLE, MUL, DIV).
REQ-032 The iterative engine SHALL be sub-module muldiv_iter, parametrised by WIDTH, with start, op and done.
REQ-033 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32)
REQ-034 ADD a=FFFFFFFF, b=1 -> one cycle later y=0, cout=1, zero=1, ovf=0; ADD a=7FFFFFFF, b=1 -> y=80000000, ovf=1, cout=0.
REQ-035 SLT a=FFFFFFFF, b=1 -> y=1; SLTU same operands -> y=0; SRA a=80000000, b=4 -> y=F8000000.
REQ-036 MULTU a=FFFFFFFF, b=2 -> in_ready=0 for 32 cycles, out_valid 33 cycles after accept, hi=1, lo=y=FFFFFFFE; then MFHI -> y=1.
REQ-037 DIVU 100/7 -> lo=14, hi=2; DIVU 5/0 -> lo=FFFFFFFF, hi=5.
REQ-038 Hold out_ready=0 for 3 cycles after an ADD result -> y stable, in_ready=0; then back-to-back ops with out_ready=1 -> one result per cycle.
REQ-039 Assert reset_n=0 at cycle 10 of a MULTU -> out_valid=0, hi=lo=0 immediately; after release in_ready=1.
